// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder. One 4-bit binary add stage
// plus a +6 decimal correction is reused for every digit.
// Latency: done pulses 2*DIGITS+1 clock edges after the edge that accepts start.
// Backpressure: none. start is only sampled in IDLE; a start seen while busy is dropped.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           request; captures A, B, Cin (and sub) when idle
//   A, B            packed BCD operands, digit 0 in [3:0]
//   Cin             decimal carry-in to digit 0
//   sub             (only with BCD_SUB_EN) 1 = ten's-complement subtract A - B
//   busy            high while an operation is in flight
//   done            one-cycle pulse, Sum/Cout/err valid
//   Sum, Cout, err  result, decimal carry out, sticky invalid-digit flag
//
// Optional feature: define BCD_SUB_EN to add the sub port and subtraction.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CORR = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic [4*DIGITS-1:0] sum_q, sum_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [4:0]          t_q, t_d;
  logic                done_q, done_d;
  logic                cout_q, cout_d;
  logic                err_q, err_d;
`ifdef BCD_SUB_EN
  logic                sub_q, sub_d;
`endif

  // Digit currently being processed; bit offset is idx*4.
  logic [IW+1:0] bit_off;
  logic [3:0]    a_dig, b_dig, b_eff, cor_dig;

  assign bit_off = {idx_q, 2'b00};
  assign a_dig   = a_q[bit_off +: 4];
  assign b_dig   = b_q[bit_off +: 4];

  // Subtraction feeds the nines' complement of B; err still looks at raw B.
`ifdef BCD_SUB_EN
  assign b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
`else
  assign b_eff = b_dig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      t_q     <= '0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      t_q     <= t_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    t_d     = t_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    err_d   = err_q;
    cor_dig = t_q[3:0];
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
`ifdef BCD_SUB_EN
          sub_d   = sub;
          // Ten's complement = nines' complement + 1 via the initial carry.
          if (sub) carry_d = 1'b1;
`endif
          sum_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        t_d = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        if ((a_dig > 4'd9) || (b_dig > 4'd9)) err_d = 1'b1;
        state_d = S_CORR;
      end

      S_CORR: begin
        if (t_q > 5'd9) begin
          cor_dig = t_q[3:0] + 4'd6;  // wraps mod 16 by width
          carry_d = 1'b1;
        end else begin
          cor_dig = t_q[3:0];
          carry_d = 1'b0;
        end
        sum_d[bit_off +: 4] = cor_dig;
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ADD;
        end
      end

      S_FIN: begin
        // Registered so done/Cout appear together on the following cycle.
        done_d  = 1'b1;
        cout_d  = carry_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl (DIGITS=4): vector table, hand-written
// corner sequences (mid-op start, reset abort, held start) and random ops
// checked against an integer-arithmetic decimal model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done, Cout, err;
  logic [W-1:0] Sum;
`ifdef BCD_SUB_EN
  logic         sub;
  logic         tb_sub = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef BCD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model: plain decimal integers ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic int pow10d();
    int p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p;
  endfunction

  // ---------------- operation driver ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
`ifdef BCD_SUB_EN
    sub = tb_sub;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    // Operands are captured; scramble the inputs to prove it.
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic op_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec,
                          input logic ee, input bit chk_sum);
    int lat;
    bit bok;
    do_op(a, b, cin, lat, bok);
    check({nm, ".latency"}, lat, 9);
    check({nm, ".busy_during"}, 32'(bok), 1);
    check({nm, ".busy_at_done"}, 32'(busy), 0);
    check({nm, ".err"}, 32'(err), 32'(ee));
    if (chk_sum) begin
      check({nm, ".sum"}, 32'(Sum), 32'(es));
      check({nm, ".cout"}, 32'(Cout), 32'(ec));
    end
    @(posedge clk); #1;
    check({nm, ".done_pulse"}, 32'(done), 0);
    if (chk_sum) check({nm, ".sum_hold"}, 32'(Sum), 32'(es));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dn_cnt;
    int dn_at[$];

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0};
    vecs[4] = '{16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0987, 16'h0013, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    #12;
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.sum",  32'(Sum), 0);
    check("reset.cout", 32'(Cout), 0);
    check("reset.err",  32'(err), 0);
    @(negedge clk); rst = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 7; i++)
      op_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].s, vecs[i].co, 1'b0, 1'b1);

    // ---- invalid digit: err sticky until next start ----
    op_check("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("bad_digit.err_hold", 32'(err), 1);
    op_check("after_bad", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1);

    // ---- start pulsed while busy is ignored ----
    @(negedge clk); A = 16'h0001; B = 16'h0002; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dn_cnt = 0;
    for (int e = 3; e <= 28; e++) begin
      @(posedge clk); #1;
      if (done) dn_cnt++;
    end
    check("busy_start.done_count", 32'(dn_cnt), 1);
    check("busy_start.sum", 32'(Sum), 32'h0003);

    // ---- reset mid-operation ----
    @(negedge clk); A = 16'h1234; B = 16'h5678; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;          // edge 0 accepts
    @(posedge clk); @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;          // edge 3: ignored
    @(posedge clk); #1;                       // edge 4
    check("rst_mid.busy_before", 32'(busy), 1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid.busy", 32'(busy), 0);
    check("rst_mid.done", 32'(done), 0);
    check("rst_mid.sum",  32'(Sum), 0);
    check("rst_mid.cout", 32'(Cout), 0);
    check("rst_mid.err",  32'(err), 0);
    @(posedge clk);                           // edge 5 under reset
    @(negedge clk); rst = 1'b0;
    dn_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done || busy) dn_cnt++;
    end
    check("rst_mid.stays_idle", 32'(dn_cnt), 0);
    op_check("post_rst", 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    // ---- start held high: back-to-back every 10 cycles ----
    @(negedge clk); A = 16'h1234; B = 16'h5678; Cin = 1'b0; start = 1'b1;
    @(posedge clk);                           // edge 0
    dn_at.delete();
    for (int e = 1; e <= 29; e++) begin
      @(posedge clk); #1;
      if (done) begin
        dn_at.push_back(e);
        check($sformatf("held.busy_low_e%0d", e), 32'(busy), 0);
      end
    end
    start = 1'b0;
    check("held.done_count", 32'(dn_at.size()), 3);
    for (int k = 0; k < dn_at.size() && k < 3; k++)
      check($sformatf("held.done_edge%0d", k), 32'(dn_at[k]), 32'(9 + 10 * k));
    check("held.sum", 32'(Sum), 32'h6912);
    repeat (3) @(posedge clk);

    // ---- randomized ops vs decimal model ----
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb, es;
      logic         rc, ec;
      bit           bad;
      int           s;
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      rc  = 1'($urandom);
      bad = has_bad(ra) || has_bad(rb);
      s   = bcd2int(ra) + bcd2int(rb) + int'(rc);
      es  = int2bcd(s % pow10d());
      ec  = (s >= pow10d());
      op_check($sformatf("rand%0d", n), ra, rb, rc, es, ec, bad, !bad);
    end

`ifdef BCD_SUB_EN
    // ---- ten's-complement subtraction ----
    tb_sub = 1'b1;
    op_check("sub0", 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0, 1'b1);
    op_check("sub1", 16'h1234, 16'h5000, 1'b0, 16'h6234, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      logic [W-1:0] ra, rb;
      int           s;
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      s = bcd2int(ra) + (pow10d() - bcd2int(rb));
      op_check($sformatf("rsub%0d", n), ra, rb, 1'b0, int2bcd(s % pow10d()),
               bcd2int(ra) >= bcd2int(rb), 1'b0, 1'b1);
    end
    tb_sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
